// File: rtl/line_taps_pkg.sv
// Shared types and sizing helpers for the line_taps multi-row line buffer.
package line_taps_pkg;

  localparam int LT_DATA_WIDTH   = 8;
  localparam int LT_ADDR_WIDTH   = 7;
  localparam int LT_MAX_LINE_LEN = 1 << LT_ADDR_WIDTH;

  typedef logic [LT_DATA_WIDTH-1:0] pixel_t;

  function automatic int lt_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/line_taps_ram.sv
// Single-port line memory: synchronous write, read-first (the read port shows the
// old word at the address during the write cycle, so rows can be cascaded in one clock).
module line_taps_ram
  import line_taps_pkg::*;
#(
  parameter int DATA_WIDTH = LT_DATA_WIDTH,
  parameter int ADDR_WIDTH = LT_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [lt_depth(ADDR_WIDTH)];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/line_taps.sv
// TAPS-row line buffer presenting one vertically aligned pixel column per accepted sample.
// Optional build macro LINE_TAPS_ZERO_FILL_EN: rows not yet written in this frame read as zero.
module line_taps
  import line_taps_pkg::*;
#(
  parameter int DATA_WIDTH = LT_DATA_WIDTH,
  parameter int ADDR_WIDTH = LT_ADDR_WIDTH,
  parameter int TAPS       = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clken,
  input  logic                       sof,
  input  logic [ADDR_WIDTH-1:0]      line_len_m1,
  input  logic [DATA_WIDTH-1:0]      shiftin,
  output logic [TAPS*DATA_WIDTH-1:0] taps,
  output logic                       out_vld,
  output logic                       taps_vld,
  output logic [ADDR_WIDTH-1:0]      col_idx,
  output logic                       eol
);

  localparam int FILL_W = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS - 1);

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_len_m1;
  logic [FILL_W-1:0]     r_fill;

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] w_len_m1;
  logic [FILL_W-1:0]     w_fill;
  logic                  w_wrap;
  logic [DATA_WIDTH-1:0] w_wd    [TAPS-1];
  logic [DATA_WIDTH-1:0] w_rd    [TAPS-1];
  logic [DATA_WIDTH-1:0] w_slice [TAPS-1];

  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_MAX) ? f : f + 1'b1;
  endfunction

  // sof restarts the frame on this very sample: column 0, fresh length, empty fill
  assign w_ptr    = sof ? '0 : r_ptr;
  assign w_len_m1 = sof ? line_len_m1 : r_len_m1;
  assign w_fill   = sof ? '0 : r_fill;
  assign w_wrap   = (w_ptr == w_len_m1);

  for (genvar k = 0; k < TAPS - 1; k++) begin : g_row
    if (k == 0) begin : g_first
      assign w_wd[k] = shiftin;
    end else begin : g_casc
      assign w_wd[k] = w_rd[k-1];
    end

    line_taps_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .i_clk   (clk),
      .i_we    (clken),
      .i_addr  (w_ptr),
      .i_wdata (w_wd[k]),
      .o_rdata (w_rd[k])
    );

`ifdef LINE_TAPS_ZERO_FILL_EN
    assign w_slice[k] = ((k + 1) > int'(w_fill)) ? '0 : w_rd[k];
`else
    assign w_slice[k] = w_rd[k];
`endif
  end

  // output stage: column registered one clock after the accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_fill   <= '0;
      r_len_m1 <= '1;
      taps     <= '0;
      out_vld  <= 1'b0;
      taps_vld <= 1'b0;
      col_idx  <= '0;
      eol      <= 1'b0;
    end else begin
      out_vld <= clken;
      if (clken) begin
        r_len_m1 <= w_len_m1;
        r_ptr    <= w_wrap ? '0 : w_ptr + 1'b1;
        r_fill   <= (w_wrap && !sof) ? fill_sat_inc(w_fill) : w_fill;
        taps[DATA_WIDTH-1:0] <= shiftin;
        for (int k = 0; k < TAPS - 1; k++) begin
          taps[(k+1)*DATA_WIDTH +: DATA_WIDTH] <= w_slice[k];
        end
        col_idx  <= w_ptr;
        eol      <= w_wrap;
        taps_vld <= (w_fill == FILL_MAX);
      end
    end
  end

endmodule
